// File: rtl/stage_3.sv
// Execute stage of the 5-stage RISC-V pipeline.
// Holds the ID/EX register, resolves operand selects, runs the ALU (with an
// iterative 1-bit/cycle shifter) and registers results into EX/MEM.
module stage_3 #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_stall,
  input  logic            i_flush,
  input  logic            i_mem_busy,
  input  logic [XLEN-1:0] i_pc,
  input  logic [4:0]      i_rd_num,
  input  logic [XLEN-1:0] i_rs_1,
  input  logic [XLEN-1:0] i_rs_2,
  input  logic [XLEN-1:0] i_imm_ext,
  input  logic [19:0]     i_imm_20_u,
  input  logic [2:0]      i_alu_op_1,
  input  logic [2:0]      i_alu_op_2,
  input  logic [3:0]      i_alu_op,
  input  logic [2:0]      i_mem_op,
  input  logic            i_alu_mem_op,
  output logic            busy,
  output logic [4:0]      id_ex_rd_num,
  output logic [4:0]      ex_mem_rd_num,
  output logic [XLEN-1:0] alu_out,
  output logic [XLEN-1:0] store_data,
  output logic [2:0]      mem_op,
  output logic            alu_mem_op,
  output logic            reg_op,
  output logic            valid
);

  // Operand-select codes
  localparam logic [2:0] SEL_RS_1      = 3'd0;
  localparam logic [2:0] SEL_RS_2      = 3'd1;
  localparam logic [2:0] SEL_IMM_EXT   = 3'd2;
  localparam logic [2:0] SEL_PC        = 3'd3;
  localparam logic [2:0] SEL_IMM_4     = 3'd4;
  localparam logic [2:0] SEL_IMM_0     = 3'd5;
  localparam logic [2:0] SEL_LUI_AUIPC = 3'd6;

  // ALU function codes
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLT  = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  typedef enum logic {IDLE, SHIFT} state_t;

  // ID/EX register
  logic [XLEN-1:0] pc_p0, rs_1_p0, rs_2_p0, imm_ext_p0;
  logic [19:0]     imm_20_u_p0;
  logic [4:0]      rd_num_p0;
  logic [2:0]      sel_1_p0, sel_2_p0, mem_op_p0;
  logic [3:0]      alu_op_p0;
  logic            alu_mem_op_p0;
  logic            vld_p0;

  // EX/MEM register
  logic [XLEN-1:0] alu_out_p1, store_data_p1;
  logic [4:0]      rd_num_p1;
  logic [2:0]      mem_op_p1;
  logic            alu_mem_op_p1;
  logic            vld_p1;

  // Iterative shifter state
  state_t          state;
  logic [XLEN-1:0] acc;
  logic [SHAMT_W-1:0] cnt;

  logic signed [XLEN-1:0] op_1, op_2;
  logic [XLEN-1:0]        alu_res;
  logic [XLEN-1:0]        acc_next;
  logic [SHAMT_W-1:0]     shamt;
  logic                   is_shift, shift_start, shift_last;

  function automatic logic [XLEN-1:0] sel_operand(
    input logic [2:0]      sel,
    input logic [XLEN-1:0] rs_1,
    input logic [XLEN-1:0] rs_2,
    input logic [XLEN-1:0] imm_ext,
    input logic [XLEN-1:0] pc,
    input logic [19:0]     imm_u
  );
    logic [XLEN-1:0] r;
    case (sel)
      SEL_RS_1:      r = rs_1;
      SEL_RS_2:      r = rs_2;
      SEL_IMM_EXT:   r = imm_ext;
      SEL_PC:        r = pc;
      SEL_IMM_4:     r = XLEN'(4);
      SEL_IMM_0:     r = '0;
      SEL_LUI_AUIPC: r = {imm_u, 12'b0};
      default:       r = '0;
    endcase
    return r;
  endfunction

  // Shift ops return op1 unchanged here; that is the amount-0 result, any
  // non-zero amount goes through the iterative path instead.
  function automatic logic [XLEN-1:0] alu_calc(
    input logic [3:0]             op,
    input logic signed [XLEN-1:0] a,
    input logic signed [XLEN-1:0] b
  );
    logic [XLEN-1:0] r;
    case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_SLT:  r = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_SLTU: r = {{(XLEN-1){1'b0}}, ($unsigned(a) < $unsigned(b))};
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_SLL, ALU_SRL, ALU_SRA: r = a;
      default:  r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [XLEN-1:0] shift_step(
    input logic [3:0]      op,
    input logic [XLEN-1:0] a
  );
    logic signed [XLEN-1:0] s;
    logic [XLEN-1:0]        r;
    s = a;
    case (op)
      ALU_SLL: r = a << 1;
      ALU_SRL: r = a >> 1;
      ALU_SRA: r = s >>> 1;
      default: r = a;
    endcase
    return r;
  endfunction

  always_comb begin
    op_1        = sel_operand(sel_1_p0, rs_1_p0, rs_2_p0, imm_ext_p0, pc_p0, imm_20_u_p0);
    op_2        = sel_operand(sel_2_p0, rs_1_p0, rs_2_p0, imm_ext_p0, pc_p0, imm_20_u_p0);
    alu_res     = alu_calc(alu_op_p0, op_1, op_2);
    shamt       = op_2[SHAMT_W-1:0];
    is_shift    = (alu_op_p0 == ALU_SLL) || (alu_op_p0 == ALU_SRL) || (alu_op_p0 == ALU_SRA);
    shift_start = (state == IDLE) && vld_p0 && is_shift && (shamt != '0);
    shift_last  = (state == SHIFT) && (cnt == SHAMT_W'(1));
    acc_next    = shift_step(alu_op_p0, acc);
    busy        = i_mem_busy || (state == SHIFT) || shift_start;
  end

  // --- ID/EX boundary: capture decode bundle, a bubble, or retire a finished shift
  always_ff @(posedge i_clk) begin
    if (!i_rst || (!busy && (i_stall || i_flush)) || (!i_mem_busy && shift_last)) begin
      pc_p0         <= '0;
      rs_1_p0       <= '0;
      rs_2_p0       <= '0;
      imm_ext_p0    <= '0;
      imm_20_u_p0   <= '0;
      rd_num_p0     <= '0;
      sel_1_p0      <= SEL_IMM_0;
      sel_2_p0      <= SEL_IMM_0;
      alu_op_p0     <= ALU_ADD;
      mem_op_p0     <= '0;
      alu_mem_op_p0 <= 1'b0;
      vld_p0        <= 1'b0;
    end else if (!busy) begin
      pc_p0         <= i_pc;
      rs_1_p0       <= i_rs_1;
      rs_2_p0       <= i_rs_2;
      imm_ext_p0    <= i_imm_ext;
      imm_20_u_p0   <= i_imm_20_u;
      rd_num_p0     <= i_rd_num;
      sel_1_p0      <= i_alu_op_1;
      sel_2_p0      <= i_alu_op_2;
      alu_op_p0     <= i_alu_op;
      mem_op_p0     <= i_mem_op;
      alu_mem_op_p0 <= i_alu_mem_op;
      vld_p0        <= 1'b1;
    end
  end

  // --- EX/MEM boundary: shift FSM and result register, frozen while memory is busy
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state         <= IDLE;
      acc           <= '0;
      cnt           <= '0;
      alu_out_p1    <= '0;
      store_data_p1 <= '0;
      rd_num_p1     <= '0;
      mem_op_p1     <= '0;
      alu_mem_op_p1 <= 1'b0;
      vld_p1        <= 1'b0;
    end else if (!i_mem_busy) begin
      case (state)
        IDLE: begin
          if (shift_start) begin
            acc           <= op_1;
            cnt           <= shamt;
            state         <= SHIFT;
            alu_out_p1    <= '0;
            store_data_p1 <= '0;
            rd_num_p1     <= '0;
            mem_op_p1     <= '0;
            alu_mem_op_p1 <= 1'b0;
            vld_p1        <= 1'b0;
          end else begin
            alu_out_p1    <= alu_res;
            store_data_p1 <= rs_2_p0;
            rd_num_p1     <= rd_num_p0;
            mem_op_p1     <= mem_op_p0;
            alu_mem_op_p1 <= alu_mem_op_p0;
            vld_p1        <= vld_p0;
          end
        end
        SHIFT: begin
          acc <= acc_next;
          cnt <= cnt - SHAMT_W'(1);
          if (shift_last) begin
            state         <= IDLE;
            alu_out_p1    <= acc_next;
            store_data_p1 <= rs_2_p0;
            rd_num_p1     <= rd_num_p0;
            mem_op_p1     <= mem_op_p0;
            alu_mem_op_p1 <= alu_mem_op_p0;
            vld_p1        <= vld_p0;
          end else begin
            alu_out_p1    <= '0;
            store_data_p1 <= '0;
            rd_num_p1     <= '0;
            mem_op_p1     <= '0;
            alu_mem_op_p1 <= 1'b0;
            vld_p1        <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign id_ex_rd_num  = rd_num_p0;
  assign ex_mem_rd_num = rd_num_p1;
  assign alu_out       = alu_out_p1;
  assign store_data    = store_data_p1;
  assign mem_op        = mem_op_p1;
  assign alu_mem_op    = alu_mem_op_p1;
  assign valid         = vld_p1;
  assign reg_op        = vld_p1 && (rd_num_p1 != 5'd0) && !alu_mem_op_p1;

endmodule

// File: tb/tb_stage_3.sv
// Bench for stage_3: table of instructions plus hand sequences for stall/flush,
// memory freeze, back-to-back shifts and reset mid-shift.
module tb_stage_3;

  localparam logic [2:0] S_RS1 = 3'd0, S_RS2 = 3'd1, S_IMM = 3'd2, S_PC = 3'd3,
                         S_I4 = 3'd4, S_I0 = 3'd5, S_LUI = 3'd6, S_BAD = 3'd7;
  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLT = 4'd2, A_SLTU = 4'd3,
                         A_AND = 4'd4, A_OR = 4'd5, A_XOR = 4'd6, A_SLL = 4'd7,
                         A_SRL = 4'd8, A_SRA = 4'd9;

  logic        i_clk = 1'b0;
  logic        i_rst, i_stall, i_flush, i_mem_busy;
  logic [31:0] i_pc, i_rs_1, i_rs_2, i_imm_ext;
  logic [4:0]  i_rd_num;
  logic [19:0] i_imm_20_u;
  logic [2:0]  i_alu_op_1, i_alu_op_2, i_mem_op;
  logic [3:0]  i_alu_op;
  logic        i_alu_mem_op;
  logic        busy, alu_mem_op, reg_op, valid;
  logic [4:0]  id_ex_rd_num, ex_mem_rd_num;
  logic [31:0] alu_out, store_data;
  logic [2:0]  mem_op;

  stage_3 dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_stall(i_stall), .i_flush(i_flush),
    .i_mem_busy(i_mem_busy), .i_pc(i_pc), .i_rd_num(i_rd_num), .i_rs_1(i_rs_1),
    .i_rs_2(i_rs_2), .i_imm_ext(i_imm_ext), .i_imm_20_u(i_imm_20_u),
    .i_alu_op_1(i_alu_op_1), .i_alu_op_2(i_alu_op_2), .i_alu_op(i_alu_op),
    .i_mem_op(i_mem_op), .i_alu_mem_op(i_alu_mem_op), .busy(busy),
    .id_ex_rd_num(id_ex_rd_num), .ex_mem_rd_num(ex_mem_rd_num), .alu_out(alu_out),
    .store_data(store_data), .mem_op(mem_op), .alu_mem_op(alu_mem_op),
    .reg_op(reg_op), .valid(valid)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] rs1, rs2, imm;
    logic [19:0] immu;
    logic [2:0]  s1, s2;
    logic [3:0]  op;
    logic [2:0]  mop;
    logic        amo;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] out, sd;
    logic [4:0]  rd;
    logic [2:0]  mop;
    logic        amo, rop;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[20];
  int   tests = 0;
  int   fails = 0;
  logic adv = 1'b0;

  function automatic vec_t mk(logic [31:0] pc, logic [4:0] rd, logic [31:0] rs1,
      logic [31:0] rs2, logic [31:0] imm, logic [19:0] immu, logic [2:0] s1,
      logic [2:0] s2, logic [3:0] op, logic [2:0] mop, logic amo, logic [31:0] exp, int lat);
    vec_t v;
    v.pc = pc; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.immu = immu;
    v.s1 = s1; v.s2 = s2; v.op = op; v.mop = mop; v.amo = amo; v.exp = exp; v.lat = lat;
    return v;
  endfunction

  function automatic exp_t mk_exp(vec_t v);
    exp_t e;
    e.out = v.exp; e.sd = v.rs2; e.rd = v.rd; e.mop = v.mop; e.amo = v.amo;
    e.rop = (v.rd != 5'd0) && !v.amo;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input logic st, input logic fl);
    i_pc = v.pc; i_rd_num = v.rd; i_rs_1 = v.rs1; i_rs_2 = v.rs2; i_imm_ext = v.imm;
    i_imm_20_u = v.immu; i_alu_op_1 = v.s1; i_alu_op_2 = v.s2; i_alu_op = v.op;
    i_mem_op = v.mop; i_alu_mem_op = v.amo; i_stall = st; i_flush = fl;
  endtask

  task automatic drive_idle();
    i_pc = '0; i_rd_num = '0; i_rs_1 = '0; i_rs_2 = '0; i_imm_ext = '0; i_imm_20_u = '0;
    i_alu_op_1 = S_I0; i_alu_op_2 = S_I0; i_alu_op = A_ADD; i_mem_op = '0;
    i_alu_mem_op = 1'b0; i_stall = 1'b1; i_flush = 1'b0;
  endtask

  // Present one instruction once decode is allowed to hand it over.
  task automatic issue(input vec_t v);
    int n = 0;
    @(negedge i_clk);
    while (busy && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 100) chk("issue_wait_timeout", 32'(n), 32'd0);
    drive(v, 1'b0, 1'b0);
    sb.push_back(mk_exp(v));
    @(posedge i_clk);
    #1;
    chk("id_ex_rd", {27'd0, id_ex_rd_num}, {27'd0, v.rd});
    drive_idle();
  endtask

  // Count edges from capture until the result is valid in EX/MEM.
  task automatic run_lat(input string nm, input int exp_lat, input int mb_at, input int mb_len);
    int cnt = 0;
    bit done = 0;
    while (!done) begin
      @(posedge i_clk);
      #1;
      cnt++;
      if (valid) done = 1;
      else chk({nm, "_busy_wait"}, {31'd0, busy}, 32'd1);
      if (cnt >= 60) done = 1;
      if (cnt == mb_at) i_mem_busy = 1'b1;
      if (mb_len > 0 && cnt == mb_at + mb_len) i_mem_busy = 1'b0;
    end
    i_mem_busy = 1'b0;
    chk({nm, "_latency"}, 32'(cnt), 32'(exp_lat));
    chk({nm, "_busy_done"}, {31'd0, busy}, 32'd0);
  endtask

  always @(posedge i_clk) adv <= i_rst && !i_mem_busy;

  // Scoreboard: every newly landed valid result is matched in order.
  always @(negedge i_clk) begin
    if (adv && valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", {31'd0, valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("alu_out", alu_out, e.out);
        chk("store_data", store_data, e.sd);
        chk("ex_mem_rd", {27'd0, ex_mem_rd_num}, {27'd0, e.rd});
        chk("mem_op", {29'd0, mem_op}, {29'd0, e.mop});
        chk("alu_mem_op", {31'd0, alu_mem_op}, {31'd0, e.amo});
        chk("reg_op", {31'd0, reg_op}, {31'd0, e.rop});
      end
    end
  end

  task automatic chk_all_zero(input string nm);
    chk({nm, "_valid"}, {31'd0, valid}, 32'd0);
    chk({nm, "_alu_out"}, alu_out, 32'd0);
    chk({nm, "_store_data"}, store_data, 32'd0);
    chk({nm, "_ex_mem_rd"}, {27'd0, ex_mem_rd_num}, 32'd0);
    chk({nm, "_id_ex_rd"}, {27'd0, id_ex_rd_num}, 32'd0);
    chk({nm, "_mem_op"}, {29'd0, mem_op}, 32'd0);
    chk({nm, "_alu_mem_op"}, {31'd0, alu_mem_op}, 32'd0);
    chk({nm, "_reg_op"}, {31'd0, reg_op}, 32'd0);
    chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    vec_t va, vb, vc, vd, vs;

    //         pc        rd  rs1           rs2           imm           immu      s1     s2     op      mop amo exp           lat
    tbl[0]  = mk(32'h0,  3, 32'd5,        32'hFFFFFFFF, 32'h0,        20'h0,    S_RS1, S_RS2, A_ADD,  0, 0, 32'd4,        1);
    tbl[1]  = mk(32'h0,  0, 32'd5,        32'hFFFFFFFF, 32'h0,        20'h0,    S_RS1, S_RS2, A_ADD,  0, 0, 32'd4,        1);
    tbl[2]  = mk(32'h0,  4, 32'd5,        32'd7,        32'h0,        20'h0,    S_RS1, S_RS2, A_SUB,  0, 0, 32'hFFFFFFFE, 1);
    tbl[3]  = mk(32'h0,  5, 32'hFFFFFFFF, 32'd1,        32'h0,        20'h0,    S_RS1, S_RS2, A_SLT,  0, 0, 32'd1,        1);
    tbl[4]  = mk(32'h0,  5, 32'hFFFFFFFF, 32'd1,        32'h0,        20'h0,    S_RS1, S_RS2, A_SLTU, 0, 0, 32'd0,        1);
    tbl[5]  = mk(32'h0,  6, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        20'h0,    S_RS1, S_RS2, A_AND,  0, 0, 32'hF000F000, 1);
    tbl[6]  = mk(32'h0,  6, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        20'h0,    S_RS1, S_RS2, A_OR,   0, 0, 32'hFFF0FFF0, 1);
    tbl[7]  = mk(32'h0,  6, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        20'h0,    S_RS1, S_RS2, A_XOR,  0, 0, 32'h0FF00FF0, 1);
    tbl[8]  = mk(32'h100, 8, 32'h0,       32'h0,        32'h0,        20'h12345, S_PC, S_LUI, A_ADD,  0, 0, 32'h12345100, 1);
    tbl[9]  = mk(32'h100, 9, 32'h0,       32'h0,        32'h0,        20'hABCDE, S_I0, S_LUI, A_ADD,  0, 0, 32'hABCDE000, 1);
    tbl[10] = mk(32'h200, 1, 32'h0,       32'h0,        32'h0,        20'h0,    S_PC,  S_I4,  A_ADD,  0, 0, 32'h204,      1);
    tbl[11] = mk(32'h0,  0, 32'h1000,     32'hDEADBEEF, 32'hFFFFFFFC, 20'h0,    S_RS1, S_IMM, A_ADD,  2, 1, 32'hFFC,      1);
    tbl[12] = mk(32'h0,  7, 32'h2000,     32'h0,        32'd8,        20'h0,    S_RS1, S_IMM, A_ADD,  4, 1, 32'h2008,     1);
    tbl[13] = mk(32'h0,  2, 32'h77,       32'h55,       32'h0,        20'h0,    S_BAD, S_RS2, A_ADD,  0, 0, 32'h55,       1);
    tbl[14] = mk(32'h0,  2, 32'd5,        32'd7,        32'h0,        20'h0,    S_RS1, S_RS2, 4'd12,  0, 0, 32'h0,        1);
    tbl[15] = mk(32'h0, 10, 32'h1234,     32'h0,        32'h0,        20'h0,    S_RS1, S_IMM, A_SLL,  0, 0, 32'h1234,     1);
    tbl[16] = mk(32'h0, 11, 32'hF0,       32'hFFFFFFE3, 32'h0,        20'h0,    S_RS1, S_RS2, A_SRL,  0, 0, 32'h1E,       4);
    tbl[17] = mk(32'h0, 12, 32'h80000000, 32'h0,        32'd4,        20'h0,    S_RS1, S_IMM, A_SRA,  0, 0, 32'hF8000000, 5);
    tbl[18] = mk(32'h0, 13, 32'h1,        32'h0,        32'd31,       20'h0,    S_RS1, S_IMM, A_SLL,  0, 0, 32'h80000000, 32);
    tbl[19] = mk(32'h0, 14, 32'h7FFFFFF0, 32'h24,       32'h0,        20'h0,    S_RS1, S_RS2, A_SRA,  0, 0, 32'h07FFFFFF, 5);

    i_rst = 1'b0;
    i_mem_busy = 1'b0;
    drive_idle();
    repeat (3) @(posedge i_clk);
    #1;
    chk_all_zero("reset");
    @(negedge i_clk);
    i_rst = 1'b1;

    for (int i = 0; i < 20; i++) begin
      issue(tbl[i]);
      run_lat($sformatf("vec%0d", i), tbl[i].lat, 0, 0);
    end

    // Stall then flush inside a three-instruction stream
    va = mk(32'h0, 3, 32'd10, 32'd20, 32'h0, 20'h0, S_RS1, S_RS2, A_ADD, 0, 0, 32'd30, 1);
    vb = mk(32'h0, 4, 32'd10, 32'd3,  32'h0, 20'h0, S_RS1, S_RS2, A_SUB, 0, 0, 32'd7, 1);
    vd = mk(32'h0, 9, 32'd1,  32'd1,  32'h0, 20'h0, S_RS1, S_RS2, A_ADD, 0, 0, 32'd2, 1);
    vc = mk(32'h0, 5, 32'hF,  32'h3C, 32'h0, 20'h0, S_RS1, S_RS2, A_XOR, 0, 0, 32'h33, 1);
    @(negedge i_clk); drive(va, 1'b0, 1'b0); sb.push_back(mk_exp(va));
    @(posedge i_clk); #1;
    @(negedge i_clk); drive(vb, 1'b1, 1'b0);
    @(posedge i_clk); #1; chk("sf_a_valid", {31'd0, valid}, 32'd1);
    @(negedge i_clk); drive(vb, 1'b0, 1'b0); sb.push_back(mk_exp(vb));
    @(posedge i_clk); #1; chk("sf_stall_bubble", {31'd0, valid}, 32'd0);
    chk("sf_stall_rd", {27'd0, ex_mem_rd_num}, 32'd0);
    @(negedge i_clk); drive(vd, 1'b0, 1'b1);
    @(posedge i_clk); #1; chk("sf_b_valid", {31'd0, valid}, 32'd1);
    chk("sf_flush_id_ex_rd", {27'd0, id_ex_rd_num}, 32'd0);
    @(negedge i_clk); drive(vc, 1'b0, 1'b0); sb.push_back(mk_exp(vc));
    @(posedge i_clk); #1; chk("sf_flush_bubble", {31'd0, valid}, 32'd0);
    chk("sf_flush_rd", {27'd0, ex_mem_rd_num}, 32'd0);
    @(negedge i_clk); drive_idle();
    @(posedge i_clk); #1; chk("sf_c_valid", {31'd0, valid}, 32'd1);

    // SLL by 10 with memory busy for 3 cycles mid-shift
    vs = mk(32'h0, 15, 32'h3, 32'h0, 32'd10, 20'h0, S_RS1, S_IMM, A_SLL, 0, 0, 32'hC00, 14);
    issue(vs);
    run_lat("sll_freeze", 14, 3, 3);

    // Back-to-back shifts with ALU ops between them
    issue(mk(32'h0, 16, 32'h3,  32'h0, 32'd2, 20'h0, S_RS1, S_IMM, A_SLL, 0, 0, 32'hC, 3));
    issue(mk(32'h0, 17, 32'd1,  32'd2, 32'h0, 20'h0, S_RS1, S_RS2, A_ADD, 0, 0, 32'd3, 1));
    issue(mk(32'h0, 18, 32'h10, 32'h0, 32'd1, 20'h0, S_RS1, S_IMM, A_SRL, 0, 0, 32'h8, 2));
    issue(mk(32'h0, 19, 32'd4,  32'd4, 32'h0, 20'h0, S_RS1, S_RS2, A_ADD, 0, 0, 32'd8, 1));
    repeat (10) @(posedge i_clk);
    #1;
    chk("b2b_drained", 32'(sb.size()), 32'd0);

    // Reset during SHIFT aborts the shift
    issue(mk(32'h0, 20, 32'h1, 32'h0, 32'd8, 20'h0, S_RS1, S_IMM, A_SLL, 0, 0, 32'h100, 9));
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    chk_all_zero("rst_shift");
    void'(sb.pop_back());
    @(negedge i_clk);
    i_rst = 1'b1;
    issue(tbl[0]);
    run_lat("after_rst", 1, 0, 0);

    repeat (5) @(posedge i_clk);
    #1;
    chk("final_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
